skinny_input_loader: RTL and testbench
======================================

# skinny_input_loader

- Byte-serial front end for the Skinny-128-384 encryption core.
- Collects 16 plaintext bytes and 48 tweakey bytes from the 8-bit `plaintext` / `tweakey` lanes.
- Presents them as one 128-bit block plus one 384-bit tweakey with a valid/ready handshake.
- Holds the assembled block stable until the core accepts it, so the core never sees a partial load.

## Interface

Parameters:
- `PT_BYTES`, 16: plaintext bytes per block. Fixed for Skinny-128.
- `TK_BYTES`, 48: tweakey bytes per block. Fixed for TK3; sets the beat count.

Ports:
- `clock` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: byte beat valid.
- `plaintext` in 8: plaintext byte lane.
- `tweakey` in 8: tweakey byte lane.
- `reuse_key` in 1: keep the previous tweakey. Only honoured with `SKINNY_LOADER_REUSE_TK_EN`.
- `clear` in 1: abort the partial load and drop any held block.
- `load_ready` out 1: loader accepts beats.
- `load_count` out 6: beats accepted for the current block.
- `blk_valid` out 1: assembled block available.
- `blk_ready` in 1: core accepts the block.
- `pt_out` out 128: assembled plaintext.
- `tk_out` out 384: assembled tweakey.
- `protocol_err` out 1: one-cycle pulse on a rejected beat.

## Operation

- Two states: COLLECT and HOLD. `load_ready = (state==COLLECT)`; `blk_valid = (state==HOLD)`.

Reset:
- State COLLECT.
- `load_count=0`, `pt_out=0`, `tk_out=0`, `protocol_err=0`, `tk_loaded=0`.

Beat accepted (COLLECT with `load` high), with k = `load_count`:
- If k<16: `plaintext` is written to `pt_out[127-8k -: 8]`. The first byte lands in the MSB.
- If the block is a full-tweakey block: `tweakey` is written to `tk_out[383-8k -: 8]`.
- `load_count` increments.

Block length and completion:
- Block length L is 48 beats, or 16 beats when the block is in key-reuse mode (see Configuration).
- The beat with k=L-1 writes its bytes, sets `load_count=0` and moves to HOLD.
- Completing a full-tweakey block sets `tk_loaded=1`.

HOLD:
- `pt_out` and `tk_out` are frozen.
- `blk_ready` high moves to COLLECT.

Rejected beat:
- `load` while in HOLD: beat dropped, `protocol_err` pulses the next cycle.

`clear` (any state):
- Next state COLLECT, `load_count=0`, `tk_loaded=0`.
- Data registers keep their contents; they are overwritten by the next load.

Simultaneous events:
- `clear` with `load`: byte dropped, no `protocol_err`.
- `clear` with `blk_ready` in HOLD: clear wins.
- `reset` beats everything.

While COLLECT:
- `pt_out` and `tk_out` show a partially written block.
- Consumers must ignore them while `blk_valid=0`.

## Timing

- One beat per cycle. No bubbles are required between beats.
- `blk_valid` rises on the cycle after the final beat's edge.
- Minimum block latency is L cycles from the first beat to `blk_valid`.

Handshake:
- The block transfers on an edge with `blk_valid && blk_ready`.
- `load_ready` is high on the following cycle.
- A beat presented on that cycle is accepted.
- Back-to-back blocks therefore cost L+1 cycles each.

Other timing:
- `blk_ready` is ignored in COLLECT.
- `protocol_err` is registered: asserted exactly one cycle, the cycle after the rejected beat.
- Reset mid-load or mid-HOLD: the next cycle is the reset state, the partial block is lost and `blk_valid=0`.
- `load_count` never exceeds 47 and wraps only via completion, `clear` or `reset`.

## Configuration

`SKINNY_LOADER_REUSE_TK_EN`

Defined:
- `reuse_key` is sampled on the beat with k=0.
- If it is 1 and `tk_loaded=1`:
  - the block is 16 beats;
  - the `tweakey` lane is ignored;
  - `tk_out` keeps the previous tweakey.
- If it is 1 and `tk_loaded=0`, it is treated as 0 and the block is 48 beats.

Not defined:
- The `reuse_key` port exists but is ignored.
- Every block is 48 beats.
- `tk_loaded` may be optimised away.

## Test plan

- Full load, no reuse:
  - Stimulus: plaintext bytes A3,99,4B,66,AD,85,A3,45,9F,44,E9,2B,08,F5,50,CB on beats 0-15; tweakey bytes DF,88,95,48,…,C3,EB,E8 on beats 0-47.
  - Required: `blk_valid` at cycle 48, `pt_out`=128'hA3994B66AD85A3459F44E92B08F550CB, `tk_out`=384'hDF889548…18C3EBE8.
- Back-pressure:
  - Stimulus: hold `blk_ready=0` for 10 cycles after `blk_valid`; drive `load` during HOLD.
  - Required: outputs stable, `protocol_err` pulses once per rejected beat, `load_count` stays 0.
- Handshake then back-to-back:
  - Stimulus: raise `blk_ready` for one cycle; start the next block's beats on the following cycle.
  - Required: `load_ready=1` one cycle after the transfer; the second block is correct.
- Clear mid-load:
  - Stimulus: assert `clear` after 20 beats, then run a full 48-beat load.
  - Required: `load_count` reads 0, `blk_valid` only after 48 new beats.
- Key reuse, with macro defined:
  - Stimulus: full 48-beat block, then a block with `reuse_key=1` on beat 0 and plaintext 00…01.
  - Required: `blk_valid` after 16 beats, `tk_out` unchanged.
  - Stimulus: repeat after a `clear`.
  - Required: the block needs 48 beats.
- Reset in HOLD:
  - Stimulus: assert `reset` one cycle while `blk_valid=1`.
  - Required: the next cycle shows `blk_valid=0`, `load_ready=1`, `pt_out=0`, `tk_out=0`.

Source files
------------

// File: rtl/skinny_input_loader.sv
// Purpose: byte-serial loader that assembles a Skinny-128-384 block (128b plaintext + 384b tweakey).
// Latency: one beat per cycle; blk_valid rises the cycle after the last beat (48 beats, or 16 when reusing the key).
// Backpressure: block held frozen until blk_ready; beats offered during HOLD are dropped with a protocol_err pulse.
// Optional feature macro: SKINNY_LOADER_REUSE_TK_EN (16-beat blocks that keep the previously loaded tweakey).
module skinny_input_loader #(
    parameter int PT_BYTES = 16,
    parameter int TK_BYTES = 48
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [7:0]   plaintext,
    input  logic [7:0]   tweakey,
    input  logic         reuse_key,
    input  logic         clear,
    output logic         load_ready,
    output logic [5:0]   load_count,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [127:0] pt_out,
    output logic [383:0] tk_out,
    output logic         protocol_err
);

    localparam logic [5:0] PT_LAST = 6'(PT_BYTES - 1);
    localparam logic [5:0] TK_LAST = 6'(TK_BYTES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t      state;
    logic        tk_loaded;   // a complete tweakey is present in tk_out
    logic        reuse_blk;   // current block was started in key-reuse mode

    logic [6:0]  pt_base;
    logic [8:0]  tk_base;
    logic        reuse_now;
    logic        is_reuse;
    logic        last_beat;

    assign load_ready = (state == COLLECT);
    assign blk_valid  = (state == HOLD);

    // Byte placement (first byte lands in the MSB) and block-length decode for the current beat
    always_comb begin
        pt_base   = {4'(PT_LAST[3:0] - load_count[3:0]), 3'b000};
        tk_base   = {6'(TK_LAST - load_count), 3'b000};
`ifdef SKINNY_LOADER_REUSE_TK_EN
        reuse_now = reuse_key && tk_loaded;
`else
        reuse_now = 1'b0;
`endif
        // reuse_key only counts on the first beat; later beats follow the latched decision
        is_reuse  = (load_count == 6'd0) ? reuse_now : reuse_blk;
        last_beat = is_reuse ? (load_count == PT_LAST) : (load_count == TK_LAST);
    end

`ifndef SKINNY_LOADER_REUSE_TK_EN
    logic unused_cfg;
    assign unused_cfg = reuse_key ^ tk_loaded;
`endif

    // COLLECT/HOLD state machine with the data registers it fills
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= COLLECT;
            load_count   <= 6'd0;
            pt_out       <= '0;
            tk_out       <= '0;
            protocol_err <= 1'b0;
            tk_loaded    <= 1'b0;
            reuse_blk    <= 1'b0;
        end else begin
            protocol_err <= 1'b0;
            if (clear) begin
                // abort: data registers are left as-is and simply overwritten by the next load
                state      <= COLLECT;
                load_count <= 6'd0;
                tk_loaded  <= 1'b0;
                reuse_blk  <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (load) begin
                            if (load_count < 6'(PT_BYTES)) begin
                                pt_out[pt_base +: 8] <= plaintext;
                            end
                            if (!is_reuse) begin
                                tk_out[tk_base +: 8] <= tweakey;
                            end
                            if (load_count == 6'd0) begin
                                reuse_blk <= reuse_now;
                            end
                            if (last_beat) begin
                                load_count <= 6'd0;
                                state      <= HOLD;
                                if (!is_reuse) begin
                                    tk_loaded <= 1'b1;
                                end
                            end else begin
                                load_count <= load_count + 6'd1;
                            end
                        end
                    end
                    HOLD: begin
                        if (load) begin
                            protocol_err <= 1'b1;
                        end
                        if (blk_ready) begin
                            state <= COLLECT;
                        end
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_skinny_input_loader.sv
module tb_skinny_input_loader;

    logic         clock;
    logic         reset;
    logic         load;
    logic [7:0]   plaintext;
    logic [7:0]   tweakey;
    logic         reuse_key;
    logic         clear;
    logic         load_ready;
    logic [5:0]   load_count;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] pt_out;
    logic [383:0] tk_out;
    logic         protocol_err;

    int compared;
    int mismatched;

    logic [127:0] pt1, pt2, pt3;
    logic [383:0] tk1, tk2;
    logic [127:0] pt_snap;
    logic [383:0] tk_snap;
    logic         exp_err;

    skinny_input_loader dut (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .plaintext    (plaintext),
        .tweakey      (tweakey),
        .reuse_key    (reuse_key),
        .clear        (clear),
        .load_ready   (load_ready),
        .load_count   (load_count),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .pt_out       (pt_out),
        .tk_out       (tk_out),
        .protocol_err (protocol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [383:0] obs, input logic [383:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drive beats first..last-1 back to back; reuse_key is offered on the first beat only
    task automatic beats(input logic [127:0] p, input logic [383:0] t,
                         input int first, input int last, input logic reuse);
        for (int k = first; k < last; k++) begin
            load = 1'b1;
            if (k < 16) plaintext = p[127 - 8*k -: 8];
            else        plaintext = 8'($urandom);
            tweakey   = t[383 - 8*k -: 8];
            reuse_key = (k == first) ? reuse : 1'b0;
            tick();
        end
        load      = 1'b0;
        reuse_key = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        pt1 = 128'hA3994B66AD85A3459F44E92B08F550CB;
        tk1 = 384'hDF889548CFC7EA52D296339301797449AB588A34A47F1AB2DFE9C8293FBEA9A5AB1AFAC2611012CD8CEF952618C3EBE8;
        pt2 = 128'h00112233445566778899AABBCCDDEEFF;
        tk2 = 384'h0F1E2D3C4B5A69788796A5B4C3D2E1F00123456789ABCDEFFEDCBA9876543210A5A5A5A55A5A5A5AC3C3C3C33C3C3C3C;
        pt3 = 128'h00000000000000000000000000000001;
        reset = 1'b1; load = 1'b0; plaintext = 8'h00; tweakey = 8'h00;
        reuse_key = 1'b0; clear = 1'b0; blk_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // reset state
        chk("rst_blk_valid", 384'(blk_valid), 384'd0);
        chk("rst_load_ready", 384'(load_ready), 384'd1);
        chk("rst_load_count", 384'(load_count), 384'd0);
        chk("rst_pt", 384'(pt_out), 384'd0);
        chk("rst_tk", tk_out, 384'd0);
        chk("rst_perr", 384'(protocol_err), 384'd0);

        // full 48-beat load of the reference vector
        beats(pt1, tk1, 0, 47, 1'b0);
        chk("full_cnt47", 384'(load_count), 384'd47);
        chk("full_not_valid_47", 384'(blk_valid), 384'd0);
        beats(pt1, tk1, 47, 48, 1'b0);
        chk("full_valid", 384'(blk_valid), 384'd1);
        chk("full_load_ready", 384'(load_ready), 384'd0);
        chk("full_cnt0", 384'(load_count), 384'd0);
        chk("full_pt", 384'(pt_out), 384'(pt1));
        chk("full_tk", tk_out, tk1);

        // back-pressure: 10 cycles without blk_ready, beats offered on some of them
        for (int i = 0; i < 10; i++) begin
            exp_err   = (i % 3 == 0);
            load      = exp_err;
            plaintext = 8'hEE;
            tweakey   = 8'h77;
            tick();
            chk("bp_perr", 384'(protocol_err), 384'(exp_err));
        end
        load = 1'b0;
        tick();
        chk("bp_perr_drop", 384'(protocol_err), 384'd0);
        chk("bp_valid", 384'(blk_valid), 384'd1);
        chk("bp_cnt", 384'(load_count), 384'd0);
        chk("bp_pt", 384'(pt_out), 384'(pt1));
        chk("bp_tk", tk_out, tk1);

        // handshake then the next block starts on the very next cycle
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        chk("hs_load_ready", 384'(load_ready), 384'd1);
        chk("hs_valid_low", 384'(blk_valid), 384'd0);
        beats(pt2, tk2, 0, 48, 1'b0);
        chk("b2b_valid", 384'(blk_valid), 384'd1);
        chk("b2b_pt", 384'(pt_out), 384'(pt2));
        chk("b2b_tk", tk_out, tk2);
        blk_ready = 1'b1;
        tick();

        // clear after 20 beats (with a beat on the clear cycle); blk_ready held high is ignored in COLLECT
        beats(pt1, tk1, 0, 20, 1'b0);
        chk("clr_cnt20", 384'(load_count), 384'd20);
        clear = 1'b1; load = 1'b1;
        tick();
        clear = 1'b0; load = 1'b0;
        chk("clr_cnt0", 384'(load_count), 384'd0);
        chk("clr_valid", 384'(blk_valid), 384'd0);
        chk("clr_perr", 384'(protocol_err), 384'd0);
        blk_ready = 1'b0;
        beats(pt1, tk1, 0, 47, 1'b0);
        chk("clr_not_valid_47", 384'(blk_valid), 384'd0);
        beats(pt1, tk1, 47, 48, 1'b0);
        chk("clr_valid_48", 384'(blk_valid), 384'd1);
        chk("clr_pt", 384'(pt_out), 384'(pt1));
        chk("clr_tk", tk_out, tk1);
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;

`ifdef SKINNY_LOADER_REUSE_TK_EN
        // key reuse after a full block: 16 beats, tweakey untouched
        beats(pt3, tk2, 0, 16, 1'b1);
        chk("reuse_valid16", 384'(blk_valid), 384'd1);
        chk("reuse_pt", 384'(pt_out), 384'(pt3));
        chk("reuse_tk", tk_out, tk1);
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
`endif
        // reuse request without a loaded key (or feature absent): a full 48-beat block
        beats(pt3, tk2, 0, 16, 1'b1);
        chk("noreuse_valid16", 384'(blk_valid), 384'd0);
        chk("noreuse_cnt16", 384'(load_count), 384'd16);
        beats(pt3, tk2, 16, 48, 1'b0);
        chk("noreuse_valid48", 384'(blk_valid), 384'd1);
        chk("noreuse_pt", 384'(pt_out), 384'(pt3));
        chk("noreuse_tk", tk_out, tk2);

        // reset while holding a block
        pt_snap = pt_out;
        tk_snap = tk_out;
        chk("hold_pt_before_rst", 384'(pt_snap), 384'(pt3));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rsthold_valid", 384'(blk_valid), 384'd0);
        chk("rsthold_load_ready", 384'(load_ready), 384'd1);
        chk("rsthold_pt", 384'(pt_out), 384'd0);
        chk("rsthold_tk", tk_out, 384'd0);
        chk("rsthold_cnt", 384'(load_count), 384'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
